bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter with a valid/ready handshake. It runs the shift-and-add-3 (double-dabble) algorithm over one shared N-bit datapath, one bit per cycle, under a small controller state machine. It replaces the purely combinational converter where area matters or where the converter sits between streaming producers and a display/UART formatter. The output also reports the significant digit count, so downstream formatters can suppress leading zeros.

---
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per cycle,
// valid/ready handshake on both sides, reports significant digit count.
module bin2bcd_seq #(
    parameter int unsigned N = 8,
    // Decimal digits of 2^N-1: floor(N*log10(2))+1 (2^N is never a power of 10).
    localparam int unsigned D = (N * 30103) / 100000 + 1,
    localparam int unsigned L = $clog2(D + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*D-1:0]   out_bcd,
    output logic [L-1:0]     out_len,
    output logic             busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [N-1:0]      bin_q;
    logic [4*D-1:0]    bcd_q;
    logic [CW-1:0]     cnt;
    logic [4*D-1:0]    bcd_adj;
    logic [4*D-1:0]    bcd_shift;
    logic [L-1:0]      len_next;
    logic              last_bit;

    assign last_bit  = (cnt == CW'(N - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Add-3 adjust on every nibble >= 5, then shift the binary MSB into the BCD LSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < D; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[4*D-2:0], bin_q[N-1]};
    end

    // Significant digit count of the post-shift value; all-zero reports one digit.
    always_comb begin
        len_next = L'(1);
        for (int unsigned i = 0; i < D; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                len_next = L'(i + 1);
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, N shift cycles in CONV, hold in DONE until consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CONV;
            CONV:    if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared datapath: load on accept, shift during CONV, capture the result on the last shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt     <= '0;
            out_bcd <= '0;
            out_len <= L'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q <= in_data;
                        bcd_q <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_shift;
                    bin_q <= bin_q << 1;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        out_bcd <= bcd_shift;
                        out_len <= len_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq at N=8 and N=16 against a divide-by-10 model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  id8;
    logic [11:0] ob8;
    logic [1:0]  ol8;
    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] id16;
    logic [19:0] ob16;
    logic [2:0]  ol16;

    typedef struct {
        logic [19:0]     bcd;
        int unsigned     len;
        longint unsigned acc;
    } exp_t;

    exp_t            q8[$];
    exp_t            q16[$];
    longint unsigned cyc = 0;
    int              total = 0;
    int              bad = 0;
    int              hs8 = 0;
    int              hs16 = 0;
    logic            pv8 = 1'b0;
    logic            pv16 = 1'b0;
    logic            done16 = 1'b0;

    bin2bcd_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_data(id8), .in_ready(ir8),
        .out_valid(ov8), .out_ready(or8), .out_bcd(ob8), .out_len(ol8), .busy(busy8)
    );

    bin2bcd_seq #(.N(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_data(id16), .in_ready(ir16),
        .out_valid(ov16), .out_ready(or16), .out_bcd(ob16), .out_len(ol16), .busy(busy16)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division, significant length from the top non-zero digit.
    function automatic exp_t model(input int unsigned v, input longint unsigned acc);
        exp_t        e;
        int unsigned x;
        int unsigned d;
        x     = v;
        e.bcd = '0;
        e.len = 1;
        e.acc = acc;
        for (int k = 0; k < 5; k++) begin
            d = x % 10;
            e.bcd[4*k +: 4] = 4'(d);
            if (d != 0) e.len = k + 1;
            x = x / 10;
        end
        return e;
    endfunction

    // Present v and wait (bounded) until it is accepted; the expectation is queued on acceptance.
    task automatic send(input int sel, input int unsigned v);
        int unsigned n;
        logic [15:0] vv;
        n  = 0;
        vv = v[15:0];
        if (sel == 0) begin id8 = vv[7:0]; iv8 = 1'b1; end
        else          begin id16 = vv;     iv16 = 1'b1; end
        while (!((sel == 0) ? ir8 : ir16)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout%0d: got no in_ready expected in_ready within 200 cycles", sel);
                return;
            end
        end
        if (sel == 0) q8.push_back(model(v, cyc));
        else          q16.push_back(model(v, cyc));
        @(negedge clk);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", q8.size(), 0);
        chk("drain16", q16.size(), 0);
    endtask

    // Monitor for N=8: latency on rising out_valid, values every valid cycle, pop on handshake.
    always @(negedge clk) begin
        #1;
        if (ov8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected8: got result %0h expected no result", ob8);
            end else begin
                if (!pv8) chk("lat8", cyc - q8[0].acc, 9);
                chk("bcd8", ob8, q8[0].bcd[11:0]);
                chk("len8", ol8, q8[0].len);
                if (or8) begin
                    hs8++;
                    void'(q8.pop_front());
                end
            end
        end
        pv8 = ov8;
    end

    // Monitor for N=16.
    always @(negedge clk) begin
        #1;
        if (ov16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected16: got result %0h expected no result", ob16);
            end else begin
                if (!pv16) chk("lat16", cyc - q16[0].acc, 17);
                chk("bcd16", ob16, q16[0].bcd);
                chk("len16", ol16, q16[0].len);
                if (or16) begin
                    hs16++;
                    void'(q16.pop_front());
                end
            end
        end
        pv16 = ov16;
    end

    task automatic sweep8();
        for (int unsigned v = 0; v < 256; v++) begin
            send(0, v);
            iv8 = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic sweep16();
        for (int i = 0; i < 1000; i++) begin
            send(1, $urandom_range(0, 65535));
            iv16 = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        send(1, 65535);
        iv16   = 1'b0;
        done16 = 1'b1;
    endtask

    initial begin
        int hs_before;
        int hs16_before;
        int unsigned n;
        rst = 1'b1;
        iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b1; or16 = 1'b1;
        id8 = '0;   id16 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready8", ir8, 1);   chk("rst_valid8", ov8, 0);
        chk("rst_bcd8", ob8, 0);     chk("rst_len8", ol8, 1);   chk("rst_busy8", busy8, 0);
        chk("rst_ready16", ir16, 1); chk("rst_valid16", ov16, 0);
        chk("rst_bcd16", ob16, 0);   chk("rst_len16", ol16, 1); chk("rst_busy16", busy16, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values, including zero and the largest 8-bit value.
        send(0, 0);   iv8 = 1'b0;
        send(0, 255); iv8 = 1'b0;
        send(0, 99);  iv8 = 1'b0;
        send(0, 7);   iv8 = 1'b0;
        drain();

        // Backpressure: result must hold while out_ready is low.
        or8 = 1'b0;
        send(0, 128);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_seen", ov8, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready8", ir8, 0);
            chk("bp_valid8", ov8, 1);
        end
        hs_before = hs8;
        or8 = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_handshakes", hs8 - hs_before, 1);
        chk("bp_valid_low", ov8, 0);

        // Input held while busy: the changed value is taken only after return to IDLE.
        send(0, 42);
        @(negedge clk);
        id8 = 8'd17;
        send(0, 17);
        iv8 = 1'b0;
        drain();

        // Reset during conversion of 200: nothing is queued, so any result is flagged.
        id8 = 8'd200;
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", ir8, 1); chk("mid_rst_valid", ov8, 0);
        chk("mid_rst_bcd", ob8, 0);   chk("mid_rst_len", ol8, 1);
        chk("mid_rst_busy", busy8, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // Full 8-bit sweep alongside random 16-bit values with random output backpressure.
        hs_before   = hs8;
        hs16_before = hs16;
        fork
            sweep8();
            sweep16();
            begin
                while (!done16) begin
                    @(negedge clk);
                    or16 = ($urandom_range(0, 3) != 0);
                end
                or16 = 1'b1;
            end
        join
        drain();
        chk("sweep8_count", hs8 - hs_before, 256);
        chk("sweep16_count", hs16 - hs16_before, 1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected completion within 2000000 time units");
        $fatal(1, "timeout");
    end

endmodule
